// File: rtl/mult_result_unpacker.sv
// ---------------------------------------------------------------------------
// mult_result_unpacker
//
// Takes packed product words from the fracturable 9x9 multiplier, queues
// them in a small FIFO, and streams each lane's sub-product one beat at a
// time. Each beat is sign- or zero-extended to OUT_WIDTH.
//
// Lane map (emitted LSB lane first):
//   mode 0 / 3 : [17:0]
//   mode 1     : [7:0], [17:8]
//   mode 2     : [3:0], [7:4], [13:8], [17:14]
//   Mode 3 is reserved. It is emitted like mode 0 and pulses err_mode.
//
// Optional feature macro: UNPACKER_LANE_SUM_EN
//   When defined, this adds the in_sum input. A word accepted with in_sum=1
//   emits one beat: the truncated sum of all of its extended lanes.
//
// Ports:
//   clk, reset              clock (rising edge) and synchronous active-high reset
//   in_valid/in_ready       input handshake; in_data, in_mode and in_signed
//                           (and in_sum) are captured on accept
//   out_valid/out_ready     output handshake; out_data, out_lane and out_last
//                           are registered
//   err_mode                high during the cycle a mode-3 word is accepted
// ---------------------------------------------------------------------------
module mult_result_unpacker #(
    parameter int OUT_WIDTH  = 18,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [17:0]          in_data,
    input  logic [1:0]           in_mode,
    input  logic                 in_signed,
`ifdef UNPACKER_LANE_SUM_EN
    input  logic                 in_sum,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [1:0]           out_lane,
    output logic                 out_last,
    output logic                 err_mode
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic        sum;
        logic        sgn;
        logic [1:0]  mode;
        logic [17:0] data;
    } word_t;

    typedef enum logic {ST_IDLE, ST_EMIT} state_t;

    // Extract one lane and extend it to OUT_WIDTH.
    function automatic logic [OUT_WIDTH-1:0] lane_ext(input word_t w, input logic [1:0] lane);
        logic [17:0]          raw;
        logic [4:0]           width;
        logic                 s;
        logic [OUT_WIDTH-1:0] r;
        raw   = w.data;
        width = 5'd18;
        case (w.mode)
            2'd1: begin
                if (lane == 2'd0) begin raw = {10'b0, w.data[7:0]};  width = 5'd8;  end
                else              begin raw = {8'b0,  w.data[17:8]}; width = 5'd10; end
            end
            2'd2: begin
                case (lane)
                    2'd0:    begin raw = {14'b0, w.data[3:0]};   width = 5'd4; end
                    2'd1:    begin raw = {14'b0, w.data[7:4]};   width = 5'd4; end
                    2'd2:    begin raw = {12'b0, w.data[13:8]};  width = 5'd6; end
                    default: begin raw = {14'b0, w.data[17:14]}; width = 5'd4; end
                endcase
            end
            default: ;
        endcase
        s = w.sgn & raw[width - 5'd1];
        r = {OUT_WIDTH{s}};
        for (int i = 0; i < 18; i++) begin
            if (5'(i) < width) r[i] = raw[i];
        end
        return r;
    endfunction

    function automatic logic [1:0] last_lane(input logic [1:0] mode);
        case (mode)
            2'd1:    return 2'd1;
            2'd2:    return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Value of one beat. A sum word collapses all of its lanes into beat 0.
    function automatic logic [OUT_WIDTH-1:0] beat_value(input word_t w, input logic [1:0] lane);
        logic [OUT_WIDTH-1:0] acc;
        if (w.sum) begin
            acc = '0;
            for (int l = 0; l < 4; l++) begin
                if (2'(l) <= last_lane(w.mode)) acc = acc + lane_ext(w, 2'(l));
            end
            return acc;
        end
        return lane_ext(w, lane);
    endfunction

    function automatic logic beat_last(input word_t w, input logic [1:0] lane);
        return w.sum | (lane == last_lane(w.mode));
    endfunction

    // ---------------- input FIFO ----------------
    word_t       mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        full, empty, push, pop;
    word_t       in_word, head;

    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign in_ready = !full && !reset;
    assign push     = in_valid && in_ready;
    assign head     = mem_q[rd_ptr_q[AW-1:0]];
    assign err_mode = push && (in_mode == 2'd3);

    always_comb begin
        in_word      = '0;
        in_word.data = in_data;
        in_word.mode = in_mode;
        in_word.sgn  = in_signed;
`ifdef UNPACKER_LANE_SUM_EN
        in_word.sum  = in_sum;
`else
        in_word.sum  = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // ---------------- emitter FSM ----------------
    state_t               state_q, state_d;
    word_t                word_q, word_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic [1:0]           out_lane_q, out_lane_d;
    logic                 out_last_q, out_last_d;
    logic [1:0]           lane_nxt;

    assign lane_nxt = out_lane_q + 2'd1;

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        out_data_d = out_data_q;
        out_lane_d = out_lane_q;
        out_last_d = out_last_q;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    word_d     = head;
                    out_lane_d = 2'd0;
                    out_data_d = beat_value(head, 2'd0);
                    out_last_d = beat_last(head, 2'd0);
                    state_d    = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (!out_last_q) begin
                        out_lane_d = lane_nxt;
                        out_data_d = beat_value(word_q, lane_nxt);
                        out_last_d = beat_last(word_q, lane_nxt);
                    end else if (!empty) begin
                        // Chain straight into the next queued word without a bubble.
                        pop        = 1'b1;
                        word_d     = head;
                        out_lane_d = 2'd0;
                        out_data_d = beat_value(head, 2'd0);
                        out_last_d = beat_last(head, 2'd0);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            word_q     <= '0;
            out_data_q <= '0;
            out_lane_q <= 2'd0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            out_data_q <= out_data_d;
            out_lane_q <= out_lane_d;
            out_last_q <= out_last_d;
        end
    end

    assign out_valid = (state_q == ST_EMIT);
    assign out_data  = out_data_q;
    assign out_lane  = out_lane_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_mult_result_unpacker.sv
module tb_mult_result_unpacker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [17:0] in_data = '0;
    logic [1:0]  in_mode = '0;
    logic        in_signed = 1'b0;
`ifdef UNPACKER_LANE_SUM_EN
    logic        in_sum = 1'b0;
`endif
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [17:0] out_data;
    logic [1:0]  out_lane;
    logic        out_last;
    logic        err_mode;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mult_result_unpacker #(.OUT_WIDTH(18), .FIFO_DEPTH(2)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_mode(in_mode),
        .in_signed(in_signed),
`ifdef UNPACKER_LANE_SUM_EN
        .in_sum(in_sum),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_lane(out_lane),
        .out_last(out_last),
        .err_mode(err_mode)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word until it is accepted; the task returns 1 time unit after the accept edge.
    task automatic send(input logic [17:0] d, input logic [1:0] m, input logic s);
        bit done = 0;
        in_valid  = 1'b1;
        in_data   = d;
        in_mode   = m;
        in_signed = s;
        for (int c = 0; c < 40 && !done; c++) begin
            if (in_ready === 1'b1) done = 1;
            tick();
        end
        in_valid = 1'b0;
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL send_timeout: word %h was not accepted within 40 cycles", d);
        end
    endtask

    // Accept one beat, with bounded waiting. The caller checks the result.
    task automatic get_beat(output logic [17:0] d, output logic [1:0] l, output logic la, output bit got);
        got = 0;
        d = '0; l = '0; la = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && !got; c++) begin
            if (out_valid === 1'b1) begin
                d = out_data; l = out_lane; la = out_last; got = 1;
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests++; if (out_data !== 18'h0) begin fails++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        tests++; if (out_lane !== 2'd0) begin fails++; $display("FAIL reset_out_lane: got %0d want 0", out_lane); end
        tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        tests++; if (err_mode !== 1'b0) begin fails++; $display("FAIL reset_err_mode: got %b want 0", err_mode); end
        reset = 1'b0;
        tick();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_mode0_signed();
        logic [17:0] d; logic [1:0] l; logic la; bit got;
        send(18'h3FFFF, 2'd0, 1'b1);
        // The FIFO has just been written, so no beat is visible yet.
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL m0_latency: out_valid got %b want 0 right after accept", out_valid); end
        get_beat(d, l, la, got);
        tests++; if (!got || d !== 18'h3FFFF || l !== 2'd0 || la !== 1'b1) begin
            fails++; $display("FAIL m0_signed: got %0b data=%h lane=%0d last=%b want data=3ffff lane=0 last=1", got, d, l, la);
        end
    endtask

    task automatic test_mode1_signed();
        logic [17:0] d; logic [1:0] l; logic la; bit got;
        logic [17:0] exp_d [2];
        exp_d[0] = 18'h00005; exp_d[1] = 18'h3FFFE;
        send(18'h3FE05, 2'd1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            get_beat(d, l, la, got);
            tests++; if (!got || d !== exp_d[i] || l !== 2'(i) || la !== (i == 1)) begin
                fails++; $display("FAIL m1_signed beat %0d: got %0b data=%h lane=%0d last=%b want data=%h lane=%0d last=%0d", i, got, d, l, la, exp_d[i], i, (i == 1));
            end
        end
    endtask

    task automatic test_mode2();
        logic [17:0] d; logic [1:0] l; logic la; bit got;
        logic [17:0] exp_u [4];
        logic [17:0] exp_s [4];
        exp_u[0] = 18'd9;  exp_u[1] = 18'd6; exp_u[2] = 18'd42;     exp_u[3] = 18'd12;
        exp_s[0] = 18'h3FFF9; exp_s[1] = 18'd6; exp_s[2] = 18'h3FFEA; exp_s[3] = 18'h3FFFC;
        send(18'h32A69, 2'd2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            get_beat(d, l, la, got);
            tests++; if (!got || d !== exp_u[i] || l !== 2'(i) || la !== (i == 3)) begin
                fails++; $display("FAIL m2_unsigned beat %0d: got %0b data=%h lane=%0d last=%b want data=%h lane=%0d", i, got, d, l, la, exp_u[i], i);
            end
        end
        send(18'h32A69, 2'd2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            get_beat(d, l, la, got);
            tests++; if (!got || d !== exp_s[i] || l !== 2'(i) || la !== (i == 3)) begin
                fails++; $display("FAIL m2_signed beat %0d: got %0b data=%h lane=%0d last=%b want data=%h lane=%0d", i, got, d, l, la, exp_s[i], i);
            end
        end
    endtask

    task automatic test_mode3_err();
        logic [17:0] d; logic [1:0] l; logic la; bit got;
        in_valid = 1'b1; in_data = 18'h00123; in_mode = 2'd3; in_signed = 1'b0;
        #1;
        tests++; if (err_mode !== 1'b1) begin fails++; $display("FAIL m3_err_pulse: got %b want 1 in accept cycle", err_mode); end
        tick();
        in_valid = 1'b0;
        #1;
        tests++; if (err_mode !== 1'b0) begin fails++; $display("FAIL m3_err_width: got %b want 0 after accept", err_mode); end
        get_beat(d, l, la, got);
        tests++; if (!got || d !== 18'h00123 || l !== 2'd0 || la !== 1'b1) begin
            fails++; $display("FAIL m3_beat: got %0b data=%h lane=%0d last=%b want 00123 lane=0 last=1", got, d, l, la);
        end
    endtask

    task automatic test_backpressure();
        logic [17:0] d; logic [1:0] l; logic la; bit got;
        logic [17:0] w [4];
        int accepted = 0;
        bit acc_now;
        w[0] = 18'h00011; w[1] = 18'h00222; w[2] = 18'h03333; w[3] = 18'h04444;
        out_ready = 1'b0;
        in_mode = 2'd0; in_signed = 1'b0;
        for (int c = 0; c < 8 && accepted < 4; c++) begin
            in_data = w[accepted];
            in_valid = 1'b1;
            #1;
            acc_now = in_ready;
            tick();
            if (acc_now) accepted++;
        end
        tests++; if (accepted !== 3) begin fails++; $display("FAIL bp_accepted: got %0d want 3", accepted); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready: got %b want 0 with 4th offered", in_ready); end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            get_beat(d, l, la, got);
            tests++; if (!got || d !== w[i] || la !== 1'b1) begin
                fails++; $display("FAIL bp_order word %0d: got %0b data=%h last=%b want %h", i, got, d, la, w[i]);
            end
        end
        tick(); tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_no_dup: out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [17:0] exp_d [6];
        exp_d[0] = 18'h002; exp_d[1] = 18'h001;
        exp_d[2] = 18'h080; exp_d[3] = 18'h3FF;
        exp_d[4] = 18'h045; exp_d[5] = 18'h123;
        out_ready = 1'b0;
        send(18'h00102, 2'd1, 1'b0);
        send(18'h3FF80, 2'd1, 1'b0);
        send(18'h12345, 2'd1, 1'b0);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tests++; if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_lane !== 2'(i % 2) || out_last !== (i % 2 == 1)) begin
                fails++; $display("FAIL b2b beat %0d: valid=%b data=%h lane=%0d last=%b want valid=1 data=%h lane=%0d", i, out_valid, out_data, out_lane, out_last, exp_d[i], i % 2);
            end
            tick();
        end
        out_ready = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain: out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_sampling();
        logic [17:0] d; logic [1:0] l; logic la; bit got;
        logic [17:0] exp_d [4];
        exp_d[0] = 18'h3FFF8; exp_d[1] = 18'h3FFFF; exp_d[2] = 18'h3FFF0; exp_d[3] = 18'h00003;
        send(18'h0F0F8, 2'd2, 1'b1);
        in_mode = 2'd0; in_signed = 1'b0;
        for (int i = 0; i < 4; i++) begin
            get_beat(d, l, la, got);
            tests++; if (!got || d !== exp_d[i] || l !== 2'(i)) begin
                fails++; $display("FAIL sampling beat %0d: got %0b data=%h lane=%0d want data=%h lane=%0d", i, got, d, l, exp_d[i], i);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [17:0] d; logic [1:0] l; logic la; bit got;
        out_ready = 1'b0;
        send(18'h32A69, 2'd2, 1'b0);
        send(18'h00077, 2'd0, 1'b0);
        get_beat(d, l, la, got);
        tests++; if (!got || d !== 18'd9) begin fails++; $display("FAIL rm_lane0: got %0b data=%h want 9", got, d); end
        tests++; if (out_lane !== 2'd1 || out_valid !== 1'b1) begin fails++; $display("FAIL rm_at_lane1: lane=%0d valid=%b want lane=1 valid=1", out_lane, out_valid); end
        reset = 1'b1;
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rm_valid_drop: got %b want 0", out_valid); end
        reset = 1'b0;
        tick(); tick(); tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rm_queue_discard: out_valid got %b want 0", out_valid); end
        send(18'h3FE05, 2'd1, 1'b1);
        get_beat(d, l, la, got);
        tests++; if (!got || d !== 18'h00005 || l !== 2'd0 || la !== 1'b0) begin
            fails++; $display("FAIL rm_restart: got %0b data=%h lane=%0d last=%b want 00005 lane=0 last=0", got, d, l, la);
        end
        get_beat(d, l, la, got);
        tests++; if (!got || d !== 18'h3FFFE || l !== 2'd1 || la !== 1'b1) begin
            fails++; $display("FAIL rm_restart_lane1: got %0b data=%h lane=%0d last=%b want 3fffe lane=1 last=1", got, d, l, la);
        end
    endtask

`ifdef UNPACKER_LANE_SUM_EN
    task automatic test_lane_sum();
        logic [17:0] d; logic [1:0] l; logic la; bit got;
        in_sum = 1'b1;
        send(18'h32A69, 2'd2, 1'b1);
        in_sum = 1'b0;
        get_beat(d, l, la, got);
        tests++; if (!got || d !== 18'h3FFE5 || l !== 2'd0 || la !== 1'b1) begin
            fails++; $display("FAIL lane_sum: got %0b data=%h lane=%0d last=%b want 3ffe5 lane=0 last=1", got, d, l, la);
        end
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL lane_sum_single: out_valid got %b want 0", out_valid); end
    endtask
`endif

    initial begin
        test_reset();
        test_mode0_signed();
        test_mode1_signed();
        test_mode2();
        test_mode3_err();
        test_backpressure();
        test_back_to_back();
        test_sampling();
        test_reset_mid();
`ifdef UNPACKER_LANE_SUM_EN
        test_lane_sum();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
